// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer: FSM states, response codes, command payload.
package i2c_seq_pkg;

    localparam int unsigned CMD_W = 24;

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BSY,
        S_WAIT_DONE,
        S_RESP,
        S_GAP
    } state_t;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK   = 2'b00;
    localparam status_t ST_NACK = 2'b01;
    localparam status_t ST_TMO  = 2'b10;

    typedef struct packed {
        logic [6:0] dev;
        logic       rw;
        logic [7:0] reg_adr;
        logic [7:0] dat;
    } cmd_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags; DEPTH must be a power of 2.
module i2c_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        cnt_nxt = cnt;
        if (do_push && !do_pop) begin
            cnt_nxt = cnt + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    // Storage is not reset; only pointers and flags are.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == CW'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Feeds queued register-access commands to the I2C byte-master and returns data/status.
// Optional NACK retry is built when I2C_SEQ_RETRY_EN is defined.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYC    = 40,
    parameter int unsigned TMO_CYC    = 8,
    parameter int unsigned MAX_RETRY  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_dev,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_dat,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_dat,
    output logic [1:0] rsp_status,
    output logic       master_st,
    output logic [7:0] master_adr_com,
    output logic [7:0] master_adr_reg,
    output logic [7:0] master_dat_reg,
    input  logic       master_en_tx,
    input  logic       master_err_ac,
    input  logic [7:0] master_rx_dat
);

    localparam int unsigned TMO_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
    localparam int unsigned GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TMO_CYC == 0
        || MAX_RETRY > 255) begin : g_param_chk
        $error("i2c_cmd_sequencer: unsupported parameter set");
    end

    state_t           state;
    state_t           state_nxt;
    cmd_t             cmd_in;
    cmd_t             cmd_head;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             en_tx_q;
    logic             tx_fall;
    logic             gap_clr;
    logic             rsp_ld;
    status_t          rsp_status_nxt;
    logic [7:0]       rsp_dat_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;

`ifdef I2C_SEQ_RETRY_EN
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RTY_W-1:0] retry_cnt;
    logic             retry_pend;
    logic             retry_inc;
    logic             retry_ok;

    assign retry_ok = (32'(retry_cnt) < MAX_RETRY);
`endif

    assign cmd_in    = {cmd_dev, cmd_rw, cmd_reg, cmd_dat};
    assign cmd_ready = ~fifo_full;
    assign push      = cmd_valid & ~fifo_full;
    assign tx_fall   = en_tx_q & ~master_en_tx;

    i2c_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (cmd_in),
        .rdata (cmd_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FLUSH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pop            = 1'b0;
        rsp_ld         = 1'b0;
        rsp_status_nxt = ST_OK;
        rsp_dat_nxt    = 8'h00;
        gap_clr        = tx_fall;
`ifdef I2C_SEQ_RETRY_EN
        retry_inc      = 1'b0;
`endif
        unique case (state)
            // The master has no reset, so wait for it to go quiet first.
            S_FLUSH: begin
                if (!master_en_tx) begin
                    gap_clr   = 1'b1;
                    state_nxt = S_GAP;
                end
            end
            S_IDLE: begin
`ifdef I2C_SEQ_RETRY_EN
                if (retry_pend) begin
                    state_nxt = S_LAUNCH;
                end else
`endif
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_nxt = S_WAIT_BSY;
            end
            S_WAIT_BSY: begin
                if (master_en_tx) begin
                    state_nxt = S_WAIT_DONE;
                end else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
                    rsp_ld         = 1'b1;
                    rsp_status_nxt = ST_TMO;
                    state_nxt      = S_RESP;
                end
            end
            S_WAIT_DONE: begin
                if (tx_fall) begin
                    if (master_err_ac) begin
`ifdef I2C_SEQ_RETRY_EN
                        if (retry_ok) begin
                            retry_inc = 1'b1;
                            state_nxt = S_GAP;
                        end else
`endif
                        begin
                            rsp_ld         = 1'b1;
                            rsp_status_nxt = ST_NACK;
                            state_nxt      = S_RESP;
                        end
                    end else begin
                        rsp_ld      = 1'b1;
                        rsp_dat_nxt = master_adr_com[0] ? master_rx_dat : 8'h00;
                        state_nxt   = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYC)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_FLUSH;
        endcase
    end

    // Operands load only on IDLE->LAUNCH and stay put while the master re-reads them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_tx_q        <= 1'b0;
            tmo_cnt        <= '0;
            gap_cnt        <= '0;
            master_st      <= 1'b0;
            master_adr_com <= 8'h00;
            master_adr_reg <= 8'h00;
            master_dat_reg <= 8'h00;
            rsp_valid      <= 1'b0;
            rsp_dat        <= 8'h00;
            rsp_status     <= ST_OK;
        end else begin
            en_tx_q   <= master_en_tx;
            master_st <= (state_nxt == S_LAUNCH);
            if (state == S_LAUNCH) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_W'(TMO_CYC)) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (gap_clr) begin
                gap_cnt <= '0;
            end else if (gap_cnt != GAP_W'(GAP_CYC)) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
            if (pop) begin
                master_adr_com <= {cmd_head.dev, cmd_head.rw};
                master_adr_reg <= cmd_head.reg_adr;
                master_dat_reg <= cmd_head.dat;
            end
            if (rsp_ld) begin
                rsp_valid  <= 1'b1;
                rsp_dat    <= rsp_dat_nxt;
                rsp_status <= rsp_status_nxt;
            end else if (state == S_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef I2C_SEQ_RETRY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
        end else begin
            if (pop) begin
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + RTY_W'(1);
            end
            if (retry_inc) begin
                retry_pend <= 1'b1;
            end else if (state == S_LAUNCH) begin
                retry_pend <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed scoreboard bench for i2c_cmd_sequencer with a behavioural I2C byte-master model.
module tb_i2c_cmd_sequencer;
    import i2c_seq_pkg::*;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned GAP_CYC    = 40;
    localparam int unsigned TMO_CYC    = 8;
    localparam int unsigned MAX_RETRY  = 2;
    localparam int          BUSY       = 1080;
`ifdef I2C_SEQ_RETRY_EN
    localparam int          NACK_ALL_ST = 3;
    localparam int          NACK_ONE_ST = 2;
    localparam logic [9:0]  NACK_ONE_RSP = {ST_OK, 8'h5A};
`else
    localparam int          NACK_ALL_ST = 1;
    localparam int          NACK_ONE_ST = 1;
    localparam logic [9:0]  NACK_ONE_RSP = {ST_NACK, 8'h00};
`endif

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_dev;
    logic       cmd_rw;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_dat;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_dat;
    logic [1:0] rsp_status;
    logic       master_st;
    logic [7:0] master_adr_com;
    logic [7:0] master_adr_reg;
    logic [7:0] master_dat_reg;
    logic       master_en_tx  = 1'b0;
    logic       master_err_ac = 1'b0;
    logic [7:0] master_rx_dat = 8'h00;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] sb[$];
    int         rsp_seen  = 0;
    int         n_sent    = 0;
    int         n_drop    = 0;
    int         cyc       = 0;
    int         last_fall = 0;
    bit         have_fall = 1'b0;
    logic       en_prev   = 1'b0;

    // Master model knobs (written by stimulus) and state (written by model).
    bit         dead      = 1'b0;
    int         nack_base = 0;
    int         nack_n    = 0;
    logic [7:0] rx_val    = 8'h00;
    int         st_total  = 0;
    int         busy      = 0;

    i2c_cmd_sequencer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP_CYC    (GAP_CYC),
        .TMO_CYC    (TMO_CYC),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_dev        (cmd_dev),
        .cmd_rw         (cmd_rw),
        .cmd_reg        (cmd_reg),
        .cmd_dat        (cmd_dat),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_dat        (rsp_dat),
        .rsp_status     (rsp_status),
        .master_st      (master_st),
        .master_adr_com (master_adr_com),
        .master_adr_reg (master_adr_reg),
        .master_dat_reg (master_dat_reg),
        .master_en_tx   (master_en_tx),
        .master_err_ac  (master_err_ac),
        .master_rx_dat  (master_rx_dat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Master: en_tx rises one clk after st, busy BUSY clks; NACKs attempts below nack_n.
    always @(posedge clk) begin
        if (master_st) st_total <= st_total + 1;
        if (master_st && !dead && !master_en_tx) begin
            master_en_tx  <= 1'b1;
            busy          <= BUSY - 1;
            master_err_ac <= ((st_total - nack_base) < nack_n);
            master_rx_dat <= rx_val;
        end else if (master_en_tx) begin
            if (busy == 0) master_en_tx <= 1'b0;
            else busy <= busy - 1;
        end
    end

    // Monitor: bus-free spacing and response scoreboard.
    always @(negedge clk) begin
        logic [9:0] e;
        cyc++;
        if (en_prev && !master_en_tx) begin
            last_fall = cyc;
            have_fall = 1'b1;
        end
        en_prev = master_en_tx;
        if (master_st && have_fall)
            chk("st_gap", 32'((cyc - last_fall) >= int'(GAP_CYC)), 32'd1);
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexp", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp", 32'({rsp_status, rsp_dat}), 32'(e));
                rsp_seen++;
            end
        end
    end

    task automatic send(input logic [6:0] dev, input logic rw, input logic [7:0] rg,
                        input logic [7:0] dt, input logic [9:0] exp);
        int n = 0;
        cmd_dev   = dev;
        cmd_rw    = rw;
        cmd_reg   = rg;
        cmd_dat   = dt;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(cmd_ready), 32'd1);
        sb.push_back(exp);
        n_sent++;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_st(input string tag, input int bound, output int n);
        n = 0;
        while (!master_st && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(master_st), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        int s0;
        int r0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_dev   = '0;
        cmd_rw    = 1'b0;
        cmd_reg   = '0;
        cmd_dat   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_master_st", 32'(master_st), 32'd0);
        chk("rst_adr_com", 32'(master_adr_com), 32'd0);
        chk("rst_adr_reg", 32'(master_adr_reg), 32'd0);
        chk("rst_dat_reg", 32'(master_dat_reg), 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("rst_rsp_dat", 32'(rsp_dat), 32'd0);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);

        // Write with ACK, latency and operand hold
        send(7'h50, 1'b0, 8'h10, 8'hA5, {ST_OK, 8'h00});
        chk("t1_st_clk1", 32'(master_st), 32'd0);
        @(negedge clk);
        chk("t1_st_clk2", 32'(master_st), 32'd1);
        chk("t1_adr_com", 32'(master_adr_com), 32'hA0);
        chk("t1_adr_reg", 32'(master_adr_reg), 32'h10);
        chk("t1_dat_reg", 32'(master_dat_reg), 32'hA5);
        @(negedge clk);
        chk("t1_st_pulse", 32'(master_st), 32'd0);
        repeat (500) @(negedge clk);
        chk("t1_hold_com", 32'(master_adr_com), 32'hA0);
        chk("t1_hold_dat", 32'(master_dat_reg), 32'hA5);
        drain("t1_drain");

        // Read, response held while rsp_ready low
        rsp_ready = 1'b0;
        rx_val    = 8'h3C;
        send(7'h50, 1'b1, 8'h22, 8'h00, {ST_OK, 8'h3C});
        wait_st("t2_st", 200, n);
        chk("t2_adr_com", 32'(master_adr_com), 32'hA1);
        chk("t2_adr_reg", 32'(master_adr_reg), 32'h22);
        n = 0;
        while (!rsp_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        repeat (5) @(negedge clk);
        chk("t2_rsp_hold", 32'(rsp_valid), 32'd1);
        chk("t2_rsp_dat_hold", 32'(rsp_dat), 32'h3C);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain("t2_drain");

        // Five back-to-back commands through a 4-deep FIFO
        rx_val = 8'h99;
        r0     = rsp_seen;
        for (int i = 0; i < 5; i++)
            send(7'(7'h10 + i), 1'(i == 2), 8'(i), 8'(8'h40 + i),
                 (i == 2) ? {ST_OK, 8'h99} : {ST_OK, 8'h00});
        chk("t3_full", 32'(cmd_ready), 32'd0);
        drain("t3_drain");
        chk("t3_count", 32'(rsp_seen - r0), 32'd5);

        // Master never responds: timeout at LAUNCH+TMO_CYC+1
        dead = 1'b1;
        send(7'h50, 1'b1, 8'h33, 8'h00, {ST_TMO, 8'h00});
        wait_st("t4_st", 200, n);
        repeat (TMO_CYC) @(negedge clk);
        chk("t4_before", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("t4_at", 32'(rsp_valid), 32'd1);
        chk("t4_status", 32'(rsp_status), 32'd2);
        drain("t4_drain");
        dead = 1'b0;
        send(7'h50, 1'b0, 8'h11, 8'h22, {ST_OK, 8'h00});
        drain("t4_next_drain");

        // NACK on every attempt
        rx_val    = 8'h77;
        nack_base = st_total;
        nack_n    = 3;
        s0        = st_total;
        send(7'h50, 1'b1, 8'h44, 8'h00, {ST_NACK, 8'h00});
        drain("t5_drain");
        chk("t5_st_count", 32'(st_total - s0), 32'(NACK_ALL_ST));

        // NACK once, then ACK
        rx_val    = 8'h5A;
        nack_base = st_total;
        nack_n    = 1;
        s0        = st_total;
        send(7'h50, 1'b1, 8'h45, 8'h00, NACK_ONE_RSP);
        drain("t6_drain");
        chk("t6_st_count", 32'(st_total - s0), 32'(NACK_ONE_ST));
        nack_n = 0;

        // Reset while the master is busy: command dropped, flush before next launch
        send(7'h50, 1'b0, 8'h55, 8'h66, {ST_OK, 8'h00});
        wait_st("t7_st", 200, n);
        repeat (200) @(negedge clk);
        chk("t7_busy", 32'(master_en_tx), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        n_drop++;
        s0 = st_total;
        repeat (2) @(negedge clk);
        chk("t7_rst_st", 32'(master_st), 32'd0);
        chk("t7_rst_rsp", 32'(rsp_valid), 32'd0);
        chk("t7_rst_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        send(7'h50, 1'b0, 8'h77, 8'h88, {ST_OK, 8'h00});
        n = 0;
        while (master_en_tx && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t7_en_low", 32'(master_en_tx), 32'd0);
        chk("t7_no_st", 32'(st_total - s0), 32'd0);
        wait_st("t7_st_after", int'(GAP_CYC) + 20, n);
        chk("t7_gap", 32'(n >= int'(GAP_CYC)), 32'd1);
        drain("t7_drain");

        repeat (10) @(negedge clk);
        chk("end_sb", 32'(sb.size()), 32'd0);
        chk("end_rsp", 32'(rsp_seen), 32'(n_sent - n_drop));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
